// File: rtl/cortex_pkg.sv
// Shared definitions for the layer-5 pyramidal path.
// Holds the Q14 fixed-point constants, the saturation limit helpers and the
// apical burst FSM state encoding.
package cortex_pkg;

  // Default Q4.14 data format
  localparam int Q_WIDTH = 18;
  localparam int Q_FRAC  = 14;

  // Q14 constants
  localparam int ONE      = 16384;  // 1.0
  localparam int HALF     = 8192;   // 0.5
  localparam int GAIN_MIN = 4096;   // 0.25
  localparam int GAIN_MAX = 32768;  // 2.0

  // Largest value representable in a signed word of the given width
  function automatic longint sat_hi(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed word of the given width
  function automatic longint sat_lo(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  // Coincidence state machine states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BURST      = 2'd1,
    ST_REFRACTORY = 2'd2
  } burst_state_e;

endpackage

// File: rtl/sat_mul_q14.sv
// Signed Q-format multiply: full-width product, arithmetic shift right by
// FRAC (rounds toward minus infinity), then saturation to the WIDTH-bit
// signed range. Purely combinational. Also used for the x2 burst boost by
// tying one operand to the constant 2.0.
module sat_mul_q14
  import cortex_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] LIM_HI = PW'(sat_hi(WIDTH));
  localparam logic signed [PW-1:0] LIM_LO = PW'(sat_lo(WIDTH));

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;

  // Sign-extend, multiply at full width, rescale and clamp
  always_comb begin
    w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    w_prod  = w_a_ext * w_b_ext;
    w_shift = w_prod >>> FRAC;
    // NOTE: every branch below assigns o_p, and the plain else covers the
    // in-range case, so no storage is implied for this combinational output.
    if (w_shift > LIM_HI) begin
      o_p = LIM_HI[WIDTH-1:0];
    end else if (w_shift < LIM_LO) begin
      o_p = LIM_LO[WIDTH-1:0];
    end else begin
      o_p = w_shift[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/apical_burst_gate.sv
// Apical burst gate: gain-modulated dendritic drive for the layer-5 path.
// Stage 1 samples basal drive and the clamped Q14 apical gain on clk_en;
// stage 2 multiplies them on the following clk_en and registers the
// saturated result. All state advances only on clk_en.
//
// Build option APICAL_BURST_EN: when defined, a coincidence FSM issues
// fixed-length bursts (output doubled, burst_active high) followed by a
// refractory period, and counts burst entries. When undefined, the FSM is
// absent, burst_active and burst_count are tied low, and dendritic_out is the
// plain saturated product with unchanged latency.
module apical_burst_gate
  import cortex_pkg::*;
#(
  parameter int WIDTH        = Q_WIDTH,
  parameter int FRAC         = Q_FRAC,
  parameter int GAIN_THRESH  = ONE + HALF,
  parameter int BASAL_THRESH = HALF,
  parameter int BURST_LEN    = 8,
  parameter int REFRAC_LEN   = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] basal_input,
  input  logic signed [WIDTH-1:0] apical_gain,
  output logic signed [WIDTH-1:0] dendritic_out,
  output logic                    out_valid,
  output logic                    burst_active,
  output logic [15:0]             burst_count
);

  localparam logic signed [WIDTH-1:0] G_MIN = WIDTH'(GAIN_MIN);
  localparam logic signed [WIDTH-1:0] G_MAX = WIDTH'(GAIN_MAX);

  // Stage-1 registers and the unboosted stage-2 product
  logic signed [WIDTH-1:0] r_basal;
  logic signed [WIDTH-1:0] r_gain;
  logic signed [WIDTH-1:0] w_gain_clamped;
  logic signed [WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0] w_out_next;

  // Output registers
  logic signed [WIDTH-1:0] r_dout;
  logic                    r_valid;

  // Clamp the incoming gain to [0.25, 2.0] before it is sampled
  always_comb begin
    // NOTE: a default assignment first keeps this block free of latches even
    // when neither clamp bound applies.
    w_gain_clamped = apical_gain;
    if (apical_gain < G_MIN) begin
      w_gain_clamped = G_MIN;
    end else if (apical_gain > G_MAX) begin
      w_gain_clamped = G_MAX;
    end
  end

  // Stage 1: sample basal drive and clamped gain on each update tick
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // sees the values from before this edge, independent of block ordering.
    if (rst) begin
      r_basal <= '0;
      r_gain  <= '0;
    end else if (clk_en) begin
      r_basal <= basal_input;
      r_gain  <= w_gain_clamped;
    end
  end

  // Stage 2 datapath: basal x gain, rescaled and saturated
  sat_mul_q14 #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .i_a (r_basal),
    .i_b (r_gain),
    .o_p (w_prod)
  );

`ifdef APICAL_BURST_EN

  localparam logic signed [WIDTH-1:0] G_TH   = WIDTH'(GAIN_THRESH);
  localparam logic signed [WIDTH-1:0] B_TH   = WIDTH'(BASAL_THRESH);
  localparam logic signed [WIDTH-1:0] TWO_Q  = WIDTH'(2 * ONE);
  localparam int                      MAXLEN = (BURST_LEN > REFRAC_LEN) ? BURST_LEN : REFRAC_LEN;
  localparam int                      CNT_W  = $clog2(MAXLEN + 1);

  burst_state_e            r_state;
  burst_state_e            w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_next_cnt;
  logic                    w_cond;
  logic                    w_enter;
  logic                    r_burst_active;
  logic [15:0]             r_burst_count;
  logic signed [WIDTH-1:0] w_boost;

  // Doubling reuses the saturating multiplier with a constant 2.0 operand
  sat_mul_q14 #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_boost (
    .i_a (w_prod),
    .i_b (TWO_Q),
    .o_p (w_boost)
  );

  assign w_cond = (r_gain >= G_TH) && (r_basal >= B_TH);

  // Next-state and next-count decision from the stage-1 registers
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cond) begin
          w_next_state = ST_BURST;
          w_next_cnt   = CNT_W'(BURST_LEN - 1);
          w_enter      = 1'b1;
        end
      end
      ST_BURST: begin
        if (r_cnt == '0) begin
          w_next_state = ST_REFRACTORY;
          w_next_cnt   = CNT_W'(REFRAC_LEN - 1);
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      ST_REFRACTORY: begin
        // The coincidence condition is deliberately ignored here
        if (r_cnt == '0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // FSM state, counter, burst flag and saturating entry count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_burst_active <= 1'b0;
      r_burst_count  <= '0;
    end else if (clk_en) begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_burst_active <= (w_next_state == ST_BURST);
      if (w_enter && (r_burst_count != 16'hFFFF)) begin
        r_burst_count <= r_burst_count + 16'd1;
      end
    end
  end

  // The boost follows the next state so it lines up with burst_active
  assign w_out_next   = (w_next_state == ST_BURST) ? w_boost : w_prod;
  assign burst_active = r_burst_active;
  assign burst_count  = r_burst_count;

`else

  // Burst parameters have no effect in this build
  logic w_unused_cfg;
  assign w_unused_cfg = ^{GAIN_THRESH, BASAL_THRESH, BURST_LEN, REFRAC_LEN};

  assign w_out_next   = w_prod;
  assign burst_active = 1'b0;
  assign burst_count  = 16'd0;

`endif

  // Stage 2 output register and one-cycle valid pulse after each tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= clk_en;
      if (clk_en) begin
        r_dout <= w_out_next;
      end
    end
  end

  assign dendritic_out = r_dout;
  assign out_valid     = r_valid;

endmodule

// File: tb/tb_apical_burst_gate.sv
// Self-checking bench for apical_burst_gate. A tick-level model (sampled
// operands, burst entry times) predicts every output on every clock; directed
// ticks with hand-computed literals pin that model. Follows APICAL_BURST_EN.
module tb_apical_burst_gate;

  localparam int BURST_LEN  = 8;
  localparam int REFRAC_LEN = 40;
  localparam int PERIOD     = BURST_LEN + REFRAC_LEN + 1;
`ifdef APICAL_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clk_en = 1'b0;
  logic signed [17:0]  basal_input = '0;
  logic signed [17:0]  apical_gain = '0;
  logic signed [17:0]  dendritic_out;
  logic                out_valid;
  logic                burst_active;
  logic [15:0]         burst_count;

  int checks = 0;
  int errors = 0;

  apical_burst_gate dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .basal_input   (basal_input),
    .apical_gain   (apical_gain),
    .dendritic_out (dendritic_out),
    .out_valid     (out_valid),
    .burst_active  (burst_active),
    .burst_count   (burst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (tick level) ----------------
  longint m_b, m_g, m_p, m_out;
  int     m_n, m_last, m_count;
  bit     m_have, m_active, m_valid, m_enter;
  bit     m_ready = 1'b0;

  function automatic longint sat18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint clamp_gain(input longint g);
    if (g < 4096) return 4096;
    if (g > 32768) return 32768;
    return g;
  endfunction

  // Burst entry happens when the previously sampled operands meet both
  // thresholds and at least PERIOD ticks have elapsed since the last entry;
  // the burst lasts BURST_LEN ticks starting at the entry tick.
  always @(posedge clk) begin
    if (rst) begin
      m_b = 0; m_g = 0; m_n = 0; m_last = 0; m_count = 0;
      m_have = 0; m_active = 0; m_valid = 0; m_out = 0;
      m_ready = 1'b1;
    end else begin
      m_valid = clk_en;
      if (clk_en) begin
        m_p     = sat18((m_b * m_g) >>> 14);
        m_enter = BURST_EN && (m_g >= 24576) && (m_b >= 8192) &&
                  (!m_have || (m_n >= m_last + PERIOD));
        if (m_enter) begin
          m_have = 1'b1;
          m_last = m_n;
          if (m_count < 65535) m_count++;
        end
        m_active = BURST_EN && m_have && ((m_n - m_last) < BURST_LEN);
        m_out    = m_active ? sat18(2 * m_p) : m_p;
        m_b      = longint'(basal_input);
        m_g      = clamp_gain(longint'(apical_gain));
        m_n++;
      end
    end
  end

  // Compare every output against the model on every falling edge
  always @(negedge clk) begin
    if (m_ready) begin
      check("model_out_valid", out_valid, m_valid);
      check("model_dendritic_out", dendritic_out, m_out);
      check("model_burst_active", burst_active, m_active);
      check("model_burst_count", burst_count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic signed [17:0] b, input logic signed [17:0] g);
    @(posedge clk);
    #2;
    basal_input = b;
    apical_gain = g;
    clk_en      = 1'b1;
    @(posedge clk);
    #2;
    clk_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_dendritic_out", dendritic_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_burst_active", burst_active, 0);
    check("reset_burst_count", burst_count, 0);
    rst = 1'b0;

    // 1. unity gain passes basal through after two ticks
    tick(18'sd8192, 18'sd16384);
    tick(18'sd8192, 18'sd16384);
    check("unity_out", dendritic_out, 8192);
    check("unity_valid", out_valid, 1);
    check("unity_no_burst", burst_active, 0);

    // 2. sub-threshold gain, then burst entry and full period
    tick(18'sd16384, 18'sd20480);
    tick(18'sd16384, 18'sd20480);
    check("subthresh_out", dendritic_out, 20480);
    tick(18'sd16384, 18'sd24576);
    check("latency_out", dendritic_out, 20480);
    tick(18'sd16384, 18'sd24576);
    check("entry_out", dendritic_out, BURST_EN ? 49152 : 24576);
    check("entry_active", burst_active, BURST_EN);
    check("entry_count", burst_count, BURST_EN ? 1 : 0);
    for (int i = 1; i <= 98; i++) begin
      tick(18'sd16384, 18'sd24576);
      if (i == 7) begin
        check("last_burst_tick_out", dendritic_out, BURST_EN ? 49152 : 24576);
        check("last_burst_tick_active", burst_active, BURST_EN);
      end
      if (i == 8) begin
        check("refrac_out", dendritic_out, 24576);
        check("refrac_active", burst_active, 0);
      end
      if (i == 48) check("refrac_end_count", burst_count, BURST_EN ? 1 : 0);
      if (i == 49) begin
        check("second_entry_count", burst_count, BURST_EN ? 2 : 0);
        check("second_entry_active", burst_active, BURST_EN);
      end
      if (i == 98) check("third_entry_count", burst_count, BURST_EN ? 3 : 0);
    end

    // 4. gain clamping and truncation toward minus infinity
    do_reset();
    tick(18'sd16384, 18'sd0);
    tick(18'sd16384, 18'sd0);
    check("clamp_low_out", dendritic_out, 4096);
    tick(-18'sd1, 18'sd4096);
    tick(-18'sd1, 18'sd4096);
    check("floor_neg_out", dendritic_out, -1);
    tick(18'sd16384, 18'sd40000);
    tick(18'sd16384, 18'sd40000);
    check("clamp_high_out", dendritic_out, BURST_EN ? 65536 : 32768);

    // 3. saturation of the product (and of the boost)
    tick(18'sd131071, 18'sd32768);
    tick(18'sd131071, 18'sd32768);
    check("sat_pos_out", dendritic_out, 131071);
    tick(-18'sd131072, 18'sd32768);
    tick(-18'sd131072, 18'sd32768);
    check("sat_neg_out", dendritic_out, -131072);

    // 6. reset (together with clk_en) on the third burst cycle
    do_reset();
    tick(18'sd16384, 18'sd24576);
    tick(18'sd16384, 18'sd24576);
    tick(18'sd16384, 18'sd24576);
    tick(18'sd16384, 18'sd24576);
    check("third_cycle_active", burst_active, BURST_EN);
    check("third_cycle_count", burst_count, BURST_EN ? 1 : 0);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #2;
    rst    = 1'b0;
    clk_en = 1'b0;
    check("midburst_rst_active", burst_active, 0);
    check("midburst_rst_out", dendritic_out, 0);
    check("midburst_rst_count", burst_count, 0);
    check("midburst_rst_valid", out_valid, 0);
    // After reset the FSM is idle: one tick of above-threshold data re-enters
    tick(18'sd16384, 18'sd24576);
    tick(18'sd16384, 18'sd24576);
    check("post_rst_entry_count", burst_count, BURST_EN ? 1 : 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
